// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: opcodes, bundle layout, FSM states.
package ctrl_pkg;

  localparam int CTRL_W       = 18;
  localparam int OPC_W        = 7;
  localparam int RESULT_SRC_W = 2;
  localparam int IMM_SRC_W    = 3;
  localparam int ALU_OP_W     = 2;
  localparam int RSVD_W       = 2;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The named fields fill 16 bits; the top two bits of the 18-bit bundle are reserved and read 0.
  typedef struct packed {
    logic [RSVD_W-1:0]       rsvd;
    logic [RESULT_SRC_W-1:0] result_src;
    logic                    mem_write;
    logic                    alu_src;
    logic [IMM_SRC_W-1:0]    imm_src;
    logic                    reg_write;
    logic [ALU_OP_W-1:0]     alu_op;
    logic                    mreq;
    logic                    is_branch;
    logic                    jump;
    logic                    is_utype;
    logic                    is_lui;
    logic                    is_jalr;
  } ctrl_t;

endpackage

// File: rtl/ctrl_main_dec.sv
// Combinational RV32I opcode decoder producing the control bundle and an illegal-opcode flag.
module ctrl_main_dec
  import ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output ctrl_t            ctrl,
  output logic             illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD:   ctrl = ctrl_t'({2'b00, 16'b01_0_1_000_1_00_1_0_0_0_0_0});
      OPC_OP_IMM: ctrl = ctrl_t'({2'b00, 16'b00_0_1_000_1_11_0_0_0_0_0_0});
      OPC_JALR:   ctrl = ctrl_t'({2'b00, 16'b00_0_1_000_1_10_0_1_1_0_0_1});
      OPC_STORE:  ctrl = ctrl_t'({2'b00, 16'b00_1_1_001_0_00_1_0_0_0_0_0});
      OPC_OP:     ctrl = ctrl_t'({2'b00, 16'b00_0_0_000_1_10_0_0_0_0_0_0});
      OPC_BRANCH: ctrl = ctrl_t'({2'b00, 16'b00_0_0_010_0_01_0_1_0_0_0_0});
      OPC_JAL:    ctrl = ctrl_t'({2'b00, 16'b10_0_0_011_1_00_0_0_1_0_0_0});
      OPC_AUIPC:  ctrl = ctrl_t'({2'b00, 16'b11_0_1_100_1_00_0_0_0_1_0_0});
      OPC_LUI:    ctrl = ctrl_t'({2'b00, 16'b11_0_1_100_1_00_0_0_0_1_1_0});
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: registers the decoded bundle and stalls fetch across data-memory waits.
// Define CTRL_TIMEOUT_EN to enable the memory-timeout fault; otherwise MEM waits indefinitely.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int ILEN           = 32,
  parameter int MEM_MIN_WAIT   = 1,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [ILEN-1:0]   instr,
  input  logic              flush,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] ctrl,
  output logic              ctrl_valid,
  output logic              stall,
  output logic              illegal,
  output logic              mem_fault
);

  localparam logic [CNT_W-1:0] MIN_WAIT    = CNT_W'(MEM_MIN_WAIT);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
`ifdef CTRL_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  ctrl_t            dec_ctrl;
  logic             dec_illegal;
  logic             accept;
  logic             honour;
  logic             timeout;
  logic             unused_instr_bits;

  ctrl_main_dec u_dec (
    .opcode  (instr[OPC_W-1:0]),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign unused_instr_bits = ^instr[ILEN-1:OPC_W];

  // Held low during reset so fetch cannot hand over an instruction that would be lost.
  assign instr_ready = (state == IDLE) && !rst;
  assign stall       = (state != IDLE);
  assign accept      = instr_valid && instr_ready;
  assign honour      = mem_ready && (cnt >= MIN_WAIT);
  assign timeout     = TIMEOUT_ON && (cnt >= TIMEOUT_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ctrl       <= '0;
      ctrl_valid <= 1'b0;
      mem_req    <= 1'b0;
      illegal    <= 1'b0;
      cnt        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
      ctrl_valid <= 1'b0;
      if (flush) begin
        state   <= IDLE;
        mem_req <= 1'b0;
        ctrl    <= '0;
        illegal <= 1'b0;
        cnt     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              ctrl    <= dec_ctrl;
              illegal <= dec_illegal;
              cnt     <= '0;
              if (dec_ctrl.mreq) begin
                state   <= MEM;
                mem_req <= 1'b1;
              end else begin
                state <= DONE;
              end
            end
          end
          MEM: begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            // A completed access beats a simultaneous timeout.
            if (honour || timeout) begin
              mem_req <= 1'b0;
              state   <= DONE;
            end
          end
          DONE: begin
            ctrl_valid <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       mem_fault <= 1'b0;
    else if (flush || accept)                      mem_fault <= 1'b0;
    else if (state == MEM && !honour && timeout)   mem_fault <= 1'b1;
  end
`else
  assign mem_fault = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: expected bundles are queued on accept and popped on ctrl_valid.
module tb_ctrl_sequencer;

  localparam int MIN_WAIT = 3;
  localparam int TO_CYC   = 6;

  typedef struct packed {
    logic [17:0] ctrl;
    logic        illegal;
    logic        fault;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        flush;
  logic        mem_req;
  logic        mem_ready;
  logic [17:0] ctrl;
  logic        ctrl_valid;
  logic        stall;
  logic        illegal;
  logic        mem_fault;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  ctrl_sequencer #(
    .ILEN(32), .MEM_MIN_WAIT(MIN_WAIT), .TIMEOUT_CYCLES(TO_CYC), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .flush(flush), .mem_req(mem_req), .mem_ready(mem_ready),
    .ctrl(ctrl), .ctrl_valid(ctrl_valid), .stall(stall), .illegal(illegal),
    .mem_fault(mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Reference decode, written straight from the opcode table.
  function automatic logic [17:0] exp_bundle(input logic [6:0] opc);
    case (opc)
      7'b0000011: return 18'b00_01_0_1_000_1_00_1_0_0_0_0_0;
      7'b0010011: return 18'b00_00_0_1_000_1_11_0_0_0_0_0_0;
      7'b1100111: return 18'b00_00_0_1_000_1_10_0_1_1_0_0_1;
      7'b0100011: return 18'b00_00_1_1_001_0_00_1_0_0_0_0_0;
      7'b0110011: return 18'b00_00_0_0_000_1_10_0_0_0_0_0_0;
      7'b1100011: return 18'b00_00_0_0_010_0_01_0_1_0_0_0_0;
      7'b1101111: return 18'b00_10_0_0_011_1_00_0_0_1_0_0_0;
      7'b0010111: return 18'b00_11_0_1_100_1_00_0_0_0_1_0_0;
      7'b0110111: return 18'b00_11_0_1_100_1_00_0_0_0_1_1_0;
      default:    return 18'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] word, input logic fault);
    exp_t e;
    e.ctrl    = exp_bundle(word[6:0]);
    e.illegal = (e.ctrl == 18'b0);
    e.fault   = fault;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] word);
    instr       = word;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    check({tag, "_valid"}, 32'(ctrl_valid), 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_ctrl"}, 32'(ctrl), 32'(e.ctrl));
      check({tag, "_illegal"}, 32'(illegal), 32'(e.illegal));
      check({tag, "_fault"}, 32'(mem_fault), 32'(e.fault));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctrl"}, 32'(ctrl), 32'd0);
    check({tag, "_cv"}, 32'(ctrl_valid), 32'd0);
    check({tag, "_mreq"}, 32'(mem_req), 32'd0);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_ill"}, 32'(illegal), 32'd0);
    check({tag, "_fault"}, 32'(mem_fault), 32'd0);
  endtask

  initial begin
    logic [31:0] others [6];
    others = '{32'h002081B3, 32'h00208463, 32'h008000EF, 32'h00001097,
               32'h123452B7, 32'h00008067};
    rst = 1'b1; instr_valid = 1'b0; instr = '0; flush = 1'b0; mem_ready = 1'b0;

    // Reset state
    tick(); tick();
    check_idle_outputs("rst");
    check("rst_ready", 32'(instr_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_rel_ready", 32'(instr_ready), 32'd1);

    // ADDI: stall for one cycle, ctrl_valid two cycles after accept
    push(32'h00500093, 1'b0);
    send(32'h00500093);
    check("addi_c1_stall", 32'(stall), 32'd1);
    check("addi_c1_ready", 32'(instr_ready), 32'd0);
    check("addi_c1_cv", 32'(ctrl_valid), 32'd0);
    check("addi_c1_mreq", 32'(mem_req), 32'd0);
    tick();
    check("addi_c2_stall", 32'(stall), 32'd0);
    check("addi_c2_mreq", 32'(mem_req), 32'd0);
    pop_compare("addi");
    tick();
    check("addi_c3_cv", 32'(ctrl_valid), 32'd0);

    // LW with mem_ready held high from MEM entry: honoured at counter=MIN_WAIT
    push(32'h0000A103, 1'b0);
    send(32'h0000A103);
    mem_ready = 1'b1;
    for (int k = 0; k <= MIN_WAIT; k++) begin
      check($sformatf("lw_mreq_c%0d", k), 32'(mem_req), 32'd1);
      check($sformatf("lw_stall_c%0d", k), 32'(stall), 32'd1);
      tick();
    end
    mem_ready = 1'b0;
    check("lw_done_mreq", 32'(mem_req), 32'd0);
    check("lw_done_cv", 32'(ctrl_valid), 32'd0);
    tick();
    pop_compare("lw");
    tick();

    // SW: early mem_ready pulse ignored, honoured at counter=5
    push(32'h00112023, 1'b0);
    send(32'h00112023);
    for (int k = 0; k <= 5; k++) begin
      mem_ready = (k == 1 || k == 5);
      check($sformatf("sw_mreq_c%0d", k), 32'(mem_req), 32'd1);
      tick();
    end
    mem_ready = 1'b0;
    check("sw_done_mreq", 32'(mem_req), 32'd0);
    tick();
    pop_compare("sw");
    tick();

    // Undefined opcode
    push(32'h0000007F, 1'b0);
    send(32'h0000007F);
    check("ill_c1_mreq", 32'(mem_req), 32'd0);
    check("ill_c1_cv", 32'(ctrl_valid), 32'd0);
    tick();
    pop_compare("ill");

    // Remaining opcodes back to back, each accepted in the previous ctrl_valid cycle
    foreach (others[i]) begin
      push(others[i], 1'b0);
      send(others[i]);
      check($sformatf("seq%0d_mreq", i), 32'(mem_req), 32'd0);
      tick();
      pop_compare($sformatf("seq%0d", i));
    end
    tick();

    // Flush during MEM at counter=2
    send(32'h0000A103);
    tick(); tick();
    check("fl_mreq_pre", 32'(mem_req), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_idle_outputs("fl_after");
    check("fl_ready", 32'(instr_ready), 32'd1);
    tick(); tick();
    check("fl_no_cv", 32'(ctrl_valid), 32'd0);

    // Flush coincident with accept discards the instruction
    instr = 32'h00500093; instr_valid = 1'b1; flush = 1'b1;
    tick();
    instr_valid = 1'b0; flush = 1'b0;
    check("flacc_stall", 32'(stall), 32'd0);
    check("flacc_ctrl", 32'(ctrl), 32'd0);
    tick();
    check("flacc_cv", 32'(ctrl_valid), 32'd0);

    // Asynchronous reset in the middle of MEM
    send(32'h0000A103);
    tick();
    check("rmid_mreq_pre", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("rmid");
    check("rmid_ready", 32'(instr_ready), 32'd0);
    #1 rst = 1'b0;
    tick();
    check("rmid_rel_ready", 32'(instr_ready), 32'd1);
    check("rmid_rel_cv", 32'(ctrl_valid), 32'd0);

`ifdef CTRL_TIMEOUT_EN
    // Timeout with mem_ready low: fault declared once counter reaches TO_CYC
    push(32'h0000A103, 1'b1);
    send(32'h0000A103);
    for (int k = 0; k <= TO_CYC; k++) begin
      check($sformatf("to_mreq_c%0d", k), 32'(mem_req), 32'd1);
      tick();
    end
    check("to_done_mreq", 32'(mem_req), 32'd0);
    tick();
    pop_compare("to");
    // Coincident mem_ready at counter=TO_CYC wins; fault clears on accept
    push(32'h0000A103, 1'b0);
    send(32'h0000A103);
    check("to2_fault_clr", 32'(mem_fault), 32'd0);
    for (int k = 0; k <= TO_CYC; k++) begin
      mem_ready = (k == TO_CYC);
      tick();
    end
    mem_ready = 1'b0;
    tick();
    pop_compare("to2");
    tick();
`endif

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
